// File: rtl/load_store_unit.sv
// load_store_unit: checks each load/store for size, range and alignment, then sequences
// data_memory_interface beats. Define MISALIGNED_SPLIT_EN to split word-crossing accesses.
`ifndef DATA_BEGIN
`define DATA_BEGIN 32'h0000_1000
`endif
`ifndef DATA_END
`define DATA_END 32'h0000_1FFF
`endif

module load_store_unit #(
   parameter logic [31:0] RANGE_BEGIN = `DATA_BEGIN,
   parameter logic [31:0] RANGE_END   = `DATA_END
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_format,
   input  logic [31:0] req_address,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_misaligned,
   output logic        resp_fault,
   output logic        mem_read_enable,
   output logic        mem_write_enable,
   output logic [2:0]  mem_data_format,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_data_fetched
);
   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_LD_ISSUE   = 3'd1;
   localparam logic [2:0] S_LD_CAPTURE = 3'd2;
   localparam logic [2:0] S_ST_ISSUE   = 3'd3;
   localparam logic [2:0] S_RESP       = 3'd4;

   logic [2:0]  state_q, state_d;
   logic        write_q, write_d;
   logic [2:0]  format_q, format_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        misaligned_q, misaligned_d;
   logic        fault_q, fault_d;
   logic        split_q, split_d;
   logic [1:0]  beat_q, beat_d;

   logic [2:0]  num_bytes;
   logic [32:0] last_byte;
   logic        size_bad, out_of_range, unaligned_bad, split_need;
   logic [31:0] split_word, beat_addr;
   logic [1:0]  last_beat;

   function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] fmt);
      case (fmt[1:0])
         2'b00:   return fmt[2] ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
         2'b01:   return fmt[2] ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
         default: return raw;
      endcase
   endfunction

   // Acceptance checks, evaluated on the live request fields.
   always_comb begin
      case (req_format[1:0])
         2'b00:   num_bytes = 3'd1;
         2'b01:   num_bytes = 3'd2;
         default: num_bytes = 3'd4;
      endcase
      size_bad     = (req_format[1:0] == 2'b11);
      last_byte    = {1'b0, req_address} + {30'd0, num_bytes} - 33'd1;
      out_of_range = (req_address < RANGE_BEGIN) || (last_byte > {1'b0, RANGE_END});
`ifdef MISALIGNED_SPLIT_EN
      unaligned_bad = 1'b0;
      split_need    = (({1'b0, req_address[1:0]} + num_bytes) > 3'd4);
`else
      unaligned_bad = ((req_format[1:0] == 2'b01) && req_address[0]) ||
                      ((req_format[1:0] == 2'b10) && (req_address[1:0] != 2'b00));
      split_need    = 1'b0;
`endif
   end

   // During a split load rdata_q temporarily holds the first (lower) word.
   always_comb begin
      split_word = 32'({mem_data_fetched, rdata_q} >> {addr_q[1:0], 3'b000});
      last_beat  = (format_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
      if (split_q && !write_q) begin
         beat_addr = {addr_q[31:2], 2'b00} + {29'd0, beat_q[0], 2'b00};
      end else if (split_q) begin
         beat_addr = addr_q + {30'd0, beat_q};
      end else begin
         beat_addr = addr_q;
      end
   end

   assign req_ready        = (state_q == S_IDLE);
   assign resp_valid       = (state_q == S_RESP);
   assign resp_rdata       = rdata_q;
   assign resp_misaligned  = misaligned_q;
   assign resp_fault       = fault_q;
   assign mem_read_enable  = (state_q == S_LD_ISSUE) || (state_q == S_LD_CAPTURE);
   assign mem_write_enable = (state_q == S_ST_ISSUE);
   assign mem_address      = (mem_read_enable || mem_write_enable) ? beat_addr : 32'd0;
   assign mem_data_format  = !split_q ? format_q : (write_q ? 3'b000 : 3'b110);
   assign mem_write_data   = split_q ? {24'd0, wdata_q[{beat_q, 3'b000} +: 8]} : wdata_q;

   always_comb begin
      // NOTE: every signal gets its default first so no path through the case infers a latch.
      state_d      = state_q;
      write_d      = write_q;
      format_d     = format_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      misaligned_d = misaligned_q;
      fault_d      = fault_q;
      split_d      = split_q;
      beat_d       = beat_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               write_d      = req_write;
               format_d     = req_format;
               addr_d       = req_address;
               wdata_d      = req_wdata;
               rdata_d      = 32'd0;
               beat_d       = 2'd0;
               fault_d      = size_bad || out_of_range;
               misaligned_d = !fault_d && unaligned_bad;
               split_d      = !fault_d && split_need;
               if (fault_d || misaligned_d) state_d = S_RESP;
               else if (req_write)          state_d = S_ST_ISSUE;
               else                         state_d = S_LD_ISSUE;
            end
         end
         S_LD_ISSUE: state_d = S_LD_CAPTURE;
         S_LD_CAPTURE: begin
            if (split_q && (beat_q == 2'd0)) begin
               rdata_d = mem_data_fetched;
               beat_d  = 2'd1;
               state_d = S_LD_ISSUE;
            end else begin
               rdata_d = extend(split_q ? split_word : mem_data_fetched, format_q);
               state_d = S_RESP;
            end
         end
         S_ST_ISSUE: begin
            if (split_q && (beat_q != last_beat)) beat_d = beat_q + 2'd1;
            else                                  state_d = S_RESP;
         end
         S_RESP:  if (resp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         write_q      <= 1'b0;
         format_q     <= 3'd0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         rdata_q      <= 32'd0;
         misaligned_q <= 1'b0;
         fault_q      <= 1'b0;
         split_q      <= 1'b0;
         beat_q       <= 2'd0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge _d values.
         state_q      <= state_d;
         write_q      <= write_d;
         format_q     <= format_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         misaligned_q <= misaligned_d;
         fault_q      <= fault_d;
         split_q      <= split_d;
         beat_q       <= beat_d;
      end
   end
endmodule
